// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: op codes, FSM states and
// small decode helpers used by both the stage and its alignment unit.
package mem_stage_pkg;

  localparam int unsigned MEM_OP_BUS = 4;

  typedef enum logic [MEM_OP_BUS-1:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LW  = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8
  } mem_op_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Codes 9..15 are unused and behave as NOP.
  function automatic logic is_mem_op(input logic [MEM_OP_BUS-1:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_store(input logic [MEM_OP_BUS-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [MEM_OP_BUS-1:0] op,
                                         input logic [1:0]            off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store strobes and lane replication, load lane
// extraction with sign/zero extension, and the misalignment check.
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [MEM_OP_BUS-1:0] op,
  input  logic [1:0]            byte_off,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [DATA_W-1:0]     rdata,
  output logic [3:0]            strb,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     load_data,
  output logic                  misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = rdata[{byte_off, 3'b000} +: 8];
    lane_h     = byte_off[1] ? rdata[31:16] : rdata[15:0];
    strb       = '0;
    wdata      = '0;
    load_data  = '0;
    misaligned = is_misaligned(op, byte_off);
    case (op)
      OP_LB:  begin strb = '1; load_data = {{(DATA_W-8){lane_b[7]}}, lane_b};   end
      OP_LBU: begin strb = '1; load_data = {{(DATA_W-8){1'b0}}, lane_b};        end
      OP_LH:  begin strb = '1; load_data = {{(DATA_W-16){lane_h[15]}}, lane_h}; end
      OP_LHU: begin strb = '1; load_data = {{(DATA_W-16){1'b0}}, lane_h};       end
      OP_LW:  begin strb = '1; load_data = rdata;                               end
      OP_SB:  begin
        strb  = 4'b0001 << byte_off;
        wdata = {(DATA_W/8){store_data[7:0]}};
      end
      OP_SH:  begin
        strb  = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata = {(DATA_W/16){store_data[15:0]}};
      end
      OP_SW:  begin strb = '1; wdata = store_data; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage with folded MEM/WB register: issues loads/stores on an
// SRAM-like request/response bus and stalls upstream while a access is open.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     mem_reg_write_data,
  input  logic [REG_ADDR_W-1:0] mem_reg_write_addr,
  input  logic                  mem_reg_write_en,
  input  logic [3:0]            mem_op,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_store_data,
  output logic                  stall_req,
  output logic                  addr_err,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [3:0]            data_strb,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_W-1:0]     data_rdata,
  output logic [DATA_W-1:0]     wb_reg_write_data,
  output logic [REG_ADDR_W-1:0] wb_reg_write_addr,
  output logic                  wb_reg_write_en
);

  logic [1:0]            state;
  logic [3:0]            op_q;
  logic [1:0]            off_q;
  logic [REG_ADDR_W-1:0] waddr_q;
  logic                  wen_q;
  logic [DATA_W-1:0]     ld_q;

  logic [3:0]            align_op;
  logic [1:0]            align_off;
  logic [3:0]            align_strb;
  logic [DATA_W-1:0]     align_wdata;
  logic [DATA_W-1:0]     align_load;
  logic                  align_mis;

  // One alignment unit serves both phases: in IDLE it decodes the incoming op
  // (strobes, replication, misalignment); afterwards it extracts the load lane
  // for the captured op so rdata can be reduced the cycle it arrives.
  always_comb begin
    align_op  = (state == S_IDLE) ? mem_op        : op_q;
    align_off = (state == S_IDLE) ? mem_addr[1:0] : off_q;
  end

  mem_align #(.DATA_W(DATA_W)) u_align (
    .op         (align_op),
    .byte_off   (align_off),
    .store_data (mem_store_data),
    .rdata      (data_rdata),
    .strb       (align_strb),
    .wdata      (align_wdata),
    .load_data  (align_load),
    .misaligned (align_mis)
  );

  always_comb begin
    data_req  = (state == S_REQ);
    stall_req = ((state == S_IDLE) && is_mem_op(mem_op) && !align_mis)
              || (state == S_REQ) || (state == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      op_q              <= '0;
      off_q             <= '0;
      waddr_q           <= '0;
      wen_q             <= 1'b0;
      ld_q              <= '0;
      data_wr           <= 1'b0;
      data_addr         <= '0;
      data_strb         <= '0;
      data_wdata        <= '0;
      addr_err          <= 1'b0;
      wb_reg_write_data <= '0;
      wb_reg_write_addr <= '0;
      wb_reg_write_en   <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!is_mem_op(mem_op)) begin
            wb_reg_write_data <= mem_reg_write_data;
            wb_reg_write_addr <= mem_reg_write_addr;
            wb_reg_write_en   <= mem_reg_write_en;
          end else if (align_mis) begin
            addr_err        <= 1'b1;
            wb_reg_write_en <= 1'b0;
          end else begin
            op_q            <= mem_op;
            off_q           <= mem_addr[1:0];
            waddr_q         <= mem_reg_write_addr;
            wen_q           <= mem_reg_write_en;
            data_wr         <= is_store(mem_op);
            data_addr       <= {mem_addr[ADDR_W-1:2], 2'b00};
            data_strb       <= align_strb;
            data_wdata      <= align_wdata;
            wb_reg_write_en <= 1'b0;
            state           <= S_REQ;
          end
        end
        S_REQ: begin
          if (data_addr_ok) begin
            if (data_data_ok) begin
              ld_q  <= align_load;
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            ld_q  <= align_load;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          if (is_store(op_q)) begin
            wb_reg_write_en <= 1'b0;
          end else begin
            wb_reg_write_data <= ld_q;
            wb_reg_write_addr <= waddr_q;
            wb_reg_write_en   <= wen_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases with literal expectations
// plus randomized ops checked against a transaction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_reg_write_data;
  logic [4:0]  mem_reg_write_addr;
  logic        mem_reg_write_en;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic        stall_req;
  logic        addr_err;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [3:0]  data_strb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] wb_reg_write_data;
  logic [4:0]  wb_reg_write_addr;
  logic        wb_reg_write_en;

  int n_vec = 0;
  int n_err = 0;

  mem_stage #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_reg_write_data (mem_reg_write_data),
    .mem_reg_write_addr (mem_reg_write_addr),
    .mem_reg_write_en   (mem_reg_write_en),
    .mem_op             (mem_op),
    .mem_addr           (mem_addr),
    .mem_store_data     (mem_store_data),
    .stall_req          (stall_req),
    .addr_err           (addr_err),
    .data_req           (data_req),
    .data_wr            (data_wr),
    .data_addr          (data_addr),
    .data_strb          (data_strb),
    .data_wdata         (data_wdata),
    .data_addr_ok       (data_addr_ok),
    .data_data_ok       (data_data_ok),
    .data_rdata         (data_rdata),
    .wb_reg_write_data  (wb_reg_write_data),
    .wb_reg_write_addr  (wb_reg_write_addr),
    .wb_reg_write_en    (wb_reg_write_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic on integers.
  function automatic logic m_mis(input logic [3:0] op, input logic [31:0] a);
    if (op == 3 || op == 4 || op == 7) return (a % 2) != 0;
    if (op == 5 || op == 8) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [3:0] op, input logic [31:0] a);
    if (op == 6) return 4'(1 << (a % 4));
    if (op == 7) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
    if (op == 6) return (d & 32'hFF) * 32'h01010101;
    if (op == 7) return (d & 32'hFFFF) * 32'h00010001;
    if (op == 8) return d;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] r);
    logic [31:0] b, h;
    b = (r >> (8 * (a % 4))) & 32'hFF;
    h = (r >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (op)
      4'd1:    return (b >= 128) ? b - 32'd256 : b;
      4'd2:    return b;
      4'd3:    return (h >= 32768) ? h - 32'd65536 : h;
      4'd4:    return h;
      default: return r;
    endcase
  endfunction

  task automatic bubble();
    mem_op             = 4'd0;
    mem_reg_write_en   = 1'b0;
    mem_reg_write_data = $urandom;
    mem_reg_write_addr = 5'($urandom);
    mem_addr           = $urandom;
    mem_store_data     = $urandom;
    data_addr_ok       = 1'b0;
    data_data_ok       = 1'b0;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input logic [31:0] wd, input logic [4:0] wa,
                        input logic we, input int unsigned ad, input int unsigned dd,
                        output logic [31:0] obs_wb, output logic [3:0] obs_strb,
                        output logic [31:0] obs_wdata);
    logic is_mem, is_st, mis;
    is_mem = (op >= 1) && (op <= 8);
    is_st  = (op >= 6) && (op <= 8);
    mis    = m_mis(op, addr);
    obs_wb = '0; obs_strb = '0; obs_wdata = '0;
    mem_op = op; mem_addr = addr; mem_store_data = sdata;
    mem_reg_write_data = wd; mem_reg_write_addr = wa; mem_reg_write_en = we;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = rdata;
    @(negedge clk);
    chk("stall_detect", 32'(stall_req), 32'(is_mem && !mis));
    chk("req_idle", 32'(data_req), 32'd0);
    if (!is_mem) begin
      @(posedge clk); #1; bubble();
      @(negedge clk);
      chk("pass_data", wb_reg_write_data, wd);
      chk("pass_addr", 32'(wb_reg_write_addr), 32'(wa));
      chk("pass_en", 32'(wb_reg_write_en), 32'(we));
      chk("pass_stall", 32'(stall_req), 32'd0);
      chk("pass_adderr", 32'(addr_err), 32'd0);
      obs_wb = wb_reg_write_data;
    end else if (mis) begin
      @(posedge clk); #1; bubble();
      @(negedge clk);
      chk("mis_adderr", 32'(addr_err), 32'd1);
      chk("mis_wben", 32'(wb_reg_write_en), 32'd0);
      chk("mis_req", 32'(data_req), 32'd0);
      chk("mis_stall", 32'(stall_req), 32'd0);
    end else begin
      for (int unsigned k = 0; k <= ad; k++) begin
        @(posedge clk); #1;
        data_addr_ok = (k == ad);
        data_data_ok = (k == ad) && (dd == 0);
        @(negedge clk);
        chk("req_req", 32'(data_req), 32'd1);
        chk("req_wr", 32'(data_wr), 32'(is_st));
        chk("req_addr", data_addr, addr & 32'hFFFFFFFC);
        chk("req_strb", 32'(data_strb), 32'(m_strb(op, addr)));
        chk("req_wdata", data_wdata, m_wdata(op, sdata));
        chk("req_stall", 32'(stall_req), 32'd1);
        chk("req_wben", 32'(wb_reg_write_en), 32'd0);
        obs_strb  = data_strb;
        obs_wdata = data_wdata;
      end
      for (int unsigned j = 1; j <= dd; j++) begin
        @(posedge clk); #1;
        data_addr_ok = 1'($urandom_range(0, 1));
        data_data_ok = (j == dd);
        @(negedge clk);
        chk("wait_req", 32'(data_req), 32'd0);
        chk("wait_stall", 32'(stall_req), 32'd1);
      end
      @(posedge clk); #1;
      data_addr_ok = 1'($urandom_range(0, 1));
      data_data_ok = 1'($urandom_range(0, 1));
      data_rdata   = $urandom;
      @(negedge clk);
      chk("done_stall", 32'(stall_req), 32'd0);
      chk("done_req", 32'(data_req), 32'd0);
      chk("done_wben", 32'(wb_reg_write_en), 32'd0);
      @(posedge clk); #1; bubble();
      @(negedge clk);
      if (is_st) begin
        chk("st_wben", 32'(wb_reg_write_en), 32'd0);
      end else begin
        chk("ld_data", wb_reg_write_data, m_load(op, addr, rdata));
        chk("ld_addr", 32'(wb_reg_write_addr), 32'(wa));
        chk("ld_en", 32'(wb_reg_write_en), 32'(we));
      end
      obs_wb = wb_reg_write_data;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] o_wb, o_wd;
    logic [3:0]  o_st;
    logic [3:0]  r_op;
    logic [31:0] r_addr;

    rst = 1'b1;
    bubble();
    data_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_wbdata", wb_reg_write_data, 32'd0);
    chk("rst_wbaddr", 32'(wb_reg_write_addr), 32'd0);
    chk("rst_wben", 32'(wb_reg_write_en), 32'd0);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_adderr", 32'(addr_err), 32'd0);
    chk("rst_daddr", data_addr, 32'd0);
    chk("rst_strb", 32'(data_strb), 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_wr", 32'(data_wr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(4'd0, 32'h0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 0, 0, o_wb, o_st, o_wd);
    chk("lit_nop_data", o_wb, 32'h00001234);
    run_op(4'd5, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 5'd3, 1'b1, 0, 0, o_wb, o_st, o_wd);
    chk("lit_lw_data", o_wb, 32'hDEADBEEF);
    chk("lit_lw_strb", 32'(o_st), 32'hF);
    run_op(4'd1, 32'h103, 32'h0, 32'h80FFFFFF, 32'h0, 5'd9, 1'b1, 3, 2, o_wb, o_st, o_wd);
    chk("lit_lb_data", o_wb, 32'hFFFFFF80);
    run_op(4'd2, 32'h103, 32'h0, 32'h80FFFFFF, 32'h0, 5'd9, 1'b1, 3, 2, o_wb, o_st, o_wd);
    chk("lit_lbu_data", o_wb, 32'h00000080);
    run_op(4'd7, 32'h102, 32'h0000ABCD, 32'h0, 32'h0, 5'd4, 1'b1, 0, 0, o_wb, o_st, o_wd);
    chk("lit_sh_strb", 32'(o_st), 32'hC);
    chk("lit_sh_wdata", o_wd, 32'hABCDABCD);
    run_op(4'd5, 32'h102, 32'h0, 32'h0, 32'h0, 5'd6, 1'b1, 0, 0, o_wb, o_st, o_wd);

    // Reset while a load waits for its response.
    mem_op = 4'd5; mem_addr = 32'h200; mem_reg_write_addr = 5'd7; mem_reg_write_en = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b1; data_data_ok = 1'b0;
    @(negedge clk);
    chk("rw_req", 32'(data_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    bubble();
    @(negedge clk);
    chk("rw_wait_stall", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rw_req0", 32'(data_req), 32'd0);
    chk("rw_stall0", 32'(stall_req), 32'd0);
    chk("rw_wbdata0", wb_reg_write_data, 32'd0);
    chk("rw_wbaddr0", 32'(wb_reg_write_addr), 32'd0);
    chk("rw_wben0", 32'(wb_reg_write_en), 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rw_orphan_wben", 32'(wb_reg_write_en), 32'd0);
      chk("rw_orphan_req", 32'(data_req), 32'd0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 300; i++) begin
      r_op   = 4'($urandom_range(0, 8));
      r_addr = $urandom;
      if ($urandom_range(0, 1) == 1) r_addr = r_addr & 32'hFFFFFFFC;
      run_op(r_op, r_addr, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3), o_wb, o_st, o_wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
